// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, drives the IMEM address and presents the IF/ID payload.
// It handles decode stalls and taken-branch redirects. The IMEM has a 1-cycle synchronous read.
//
// state | meaning
// BOOT  | first cycle after reset, nothing presented yet
// RUN   | presenting the IMEM word that was read this cycle
// HOLD  | stalled, presenting the word captured in hold_q
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic [31:0] if_instr,
  output logic        if_valid
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc_q, pc_next;
  logic [31:0] if_pc_q, if_pc_next;
  logic [31:0] hold_q, hold_next;
  logic [31:0] tgt;

  assign tgt = branch_target & 32'hFFFF_FFFC;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state   <= BOOT;
      pc_q    <= RESET_PC;
      if_pc_q <= 32'h0;
      hold_q  <= 32'h0;
    end else begin
      state   <= state_next;
      pc_q    <= pc_next;
      if_pc_q <= if_pc_next;
      hold_q  <= hold_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    if_pc_next = if_pc_q;
    hold_next  = hold_q;
    if (branch_taken) begin
      if_pc_next = tgt;
      pc_next    = tgt + 32'd4;
      state_next = RUN;
    end else if (state == BOOT || !stall) begin
      if_pc_next = pc_q;
      pc_next    = pc_q + 32'd4;
      state_next = RUN;
    end else if (state == RUN) begin
      // The IMEM re-reads pc_q during the stall, so the word being presented must be captured now.
      hold_next  = imem_rdata;
      state_next = HOLD;
    end
  end

  assign imem_addr = branch_taken ? tgt : pc_q;
  assign if_pc     = if_pc_q;
  assign if_pc4    = if_pc_q + 32'd4;
  assign if_valid  = (state != BOOT);

  // Nothing is presented while booting, so show zero rather than a stale RD value.
  always_comb begin
    if_instr = imem_rdata;
    if (state == BOOT)      if_instr = 32'h0;
    else if (state == HOLD) if_instr = hold_q;
  end

endmodule
